// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide engine.
//   state_t        : engine FSM states
//   MCYCLE_OP_*    : encoding of the MCycleOp request input
//   count_width()  : iteration counter width for a given operand width
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FINISH  = 2'd2
  } state_t;

  localparam logic MCYCLE_OP_MUL = 1'b0;
  localparam logic MCYCLE_OP_DIV = 1'b1;

  // Counter must be able to hold the value WIDTH.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply/divide engine (Execute stage, beside the ALU).
// Accepts a request in IDLE, iterates WIDTH cycles, then pulses Done for one
// cycle with the results held in Result1/Result2 until the next completion.
// Ports:
//   CLK, Reset          : clock, synchronous active-high reset
//   Start               : request level, sampled only in IDLE
//   MCycleOp            : 0 = multiply, 1 = divide (latched at accept)
//   Operand1, Operand2  : multiplicand/dividend, multiplier/divisor (latched)
//   Result1, Result2    : product low/high, or quotient/remainder (registered)
//   Busy                : combinational stall request to the hazard unit
//   Done                : one-cycle completion pulse (registered)
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CNT_W = count_width(WIDTH);
  localparam int unsigned AW    = WIDTH + 2;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic               op_q;
  logic [WIDTH-1:0]   oper_q;   // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0]   acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0]   acc_lo;   // multiplier shifting out / quotient shifting in
  logic               accept;
  logic               last_iter;

  logic [WIDTH:0]     add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic [WIDTH-1:0]   hi_next, lo_next;

  assign last_iter = (count == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = COMPUTE;
      COMPUTE: if (last_iter) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs; Busy asserts in the request cycle itself.
  always_comb begin
    accept = 1'b0;
    Busy   = 1'b0;
    case (state)
      IDLE: begin
        accept = Start;
        Busy   = Start;
      end
      COMPUTE: Busy = 1'b1;
      default: ;
    endcase
  end

  // Shared WIDTH+1 adder. Divide uses it as a trial subtractor
  // (a + ~b + 1); carry out set means the difference is non-negative.
  always_comb begin
    add_a   = {1'b0, acc_hi};
    add_b   = '0;
    add_cin = 1'b0;
    if (op_q == MCYCLE_OP_DIV) begin
      add_a   = {acc_hi, acc_lo[WIDTH-1]};
      add_b   = ~{1'b0, oper_q};
      add_cin = 1'b1;
    end else if (acc_lo[0]) begin
      add_b   = {1'b0, oper_q};
    end
    {add_cout, add_sum} = AW'({1'b0, add_a}) + AW'({1'b0, add_b}) + AW'(add_cin);
  end

  // One iteration: mul shifts the whole product right; div shifts the
  // quotient in from the right and keeps the remainder only if it fits.
  always_comb begin
    hi_next = add_sum[WIDTH:1];
    lo_next = {add_sum[0], acc_lo[WIDTH-1:1]};
    if (op_q == MCYCLE_OP_DIV) begin
      hi_next = add_cout ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], add_cout};
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count   <= '0;
      op_q    <= MCYCLE_OP_MUL;
      oper_q  <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      Result1 <= '0;
      Result2 <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= (state == FINISH);
      if (accept) begin
        count  <= '0;
        op_q   <= MCycleOp;
        acc_hi <= '0;
        if (MCycleOp == MCYCLE_OP_DIV) begin
          acc_lo <= Operand1;
          oper_q <= Operand2;
        end else begin
          acc_lo <= Operand2;
          oper_q <= Operand1;
        end
      end else if (state == COMPUTE) begin
        count  <= count + CNT_W'(1);
        acc_hi <= hi_next;
        acc_lo <= lo_next;
      end
      if (state == FINISH) begin
        Result1 <= acc_lo;
        Result2 <= acc_hi;
      end
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit (WIDTH = 32): an arithmetic reference
// model with per-cycle comparison, plus directed vectors with literal results.
module tb_mcycle_unit;

  localparam int unsigned WIDTH = 32;

  logic             CLK = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic             MCycleOp = 1'b0;
  logic [WIDTH-1:0] Operand1 = '0;
  logic [WIDTH-1:0] Operand2 = '0;
  logic [WIDTH-1:0] Result1, Result2;
  logic             Busy, Done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  mcycle_unit #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request taken while idle completes WIDTH+1 edges later;
  // results are plain arithmetic on the operands seen at the accepting edge.
  bit               live = 0;
  bit               in_flight = 0;
  int               rem = 0;
  logic             exp_done = 0;
  logic [WIDTH-1:0] exp_r1 = '0, exp_r2 = '0;
  logic [WIDTH-1:0] pend_r1 = '0, pend_r2 = '0;

  always @(posedge CLK) begin
    bit take;
    logic [63:0] prod;
    live = 1;
    if (Reset) begin
      in_flight = 0; rem = 0; exp_done = 0; exp_r1 = '0; exp_r2 = '0;
    end else begin
      take = !in_flight && Start;
      exp_done = 0;
      if (in_flight) begin
        rem--;
        if (rem == 0) begin
          exp_done = 1; exp_r1 = pend_r1; exp_r2 = pend_r2; in_flight = 0;
        end
      end
      if (take) begin
        in_flight = 1;
        rem = WIDTH + 1;
        if (MCycleOp) begin
          if (Operand2 == 0) begin
            pend_r1 = '1; pend_r2 = Operand1;
          end else begin
            pend_r1 = Operand1 / Operand2; pend_r2 = Operand1 % Operand2;
          end
        end else begin
          prod = 64'(Operand1) * 64'(Operand2);
          pend_r1 = prod[31:0]; pend_r2 = prod[63:32];
        end
      end
    end
  end

  // Per-cycle comparison against the model; Busy is stalled for every
  // in-flight cycle except the last one.
  always begin
    @(negedge CLK);
    #2;
    if (live) begin
      chk("done", 64'(Done), 64'(exp_done));
      chk("busy", 64'(Busy), 64'((!in_flight && Start) || (in_flight && rem >= 2)));
      chk("result1", 64'(Result1), 64'(exp_r1));
      chk("result2", 64'(Result2), 64'(exp_r2));
      if (Done === 1'b1) done_cnt++;
    end
  end

  // Raise a request, confirm the same-cycle stall, optionally keep Start high.
  task automatic start_op(input string name, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input bit keep);
    @(negedge CLK);
    MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
    #1 chk({name, "_busy_req"}, 64'(Busy), 64'(1));
    @(negedge CLK);
    if (!keep) Start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until Done is seen.
  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      #3;
      if (Done === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'(33));
  endtask

  task automatic run_op(input string name, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r1, input logic [31:0] r2);
    start_op(name, op, a, b, 0);
    wait_done(name);
    chk({name, "_r1"}, 64'(Result1), 64'(r1));
    chk({name, "_r2"}, 64'(Result2), 64'(r2));
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    #3;
    chk("reset_r1", 64'(Result1), 64'(0));
    chk("reset_r2", 64'(Result2), 64'(0));
    chk("reset_busy", 64'(Busy), 64'(0));
    chk("reset_done", 64'(Done), 64'(0));

    // 1. small multiply, then results held with Done low
    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 32'd42, 32'd0);
    repeat (3) @(negedge CLK);
    #3;
    chk("mul7x6_held_r1", 64'(Result1), 64'(42));
    chk("mul7x6_held_done", 64'(Done), 64'(0));

    // 2. full-width product
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);

    // 3. divides
    run_op("div100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("div_msb_1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
    run_op("div_small_big", 1'b1, 32'd3, 32'd10, 32'd0, 32'd3);

    // 4. divide by zero
    run_op("div5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

    // 5. reset aborts an in-flight multiply
    start_op("abort", 1'b0, 32'd1000, 32'd1000, 0);
    repeat (9) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    #3;
    chk("abort_r1", 64'(Result1), 64'(0));
    chk("abort_r2", 64'(Result2), 64'(0));
    chk("abort_busy", 64'(Busy), 64'(0));
    d0 = done_cnt;
    repeat (40) @(negedge CLK);
    #3;
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    run_op("mul3x3", 1'b0, 32'd3, 32'd3, 32'd9, 32'd0);

    // 6. operands change after accept; Start held high through completion
    start_op("hold", 1'b0, 32'd12, 32'd11, 1);
    MCycleOp = 1'b1; Operand1 = 32'd99; Operand2 = 32'd77;
    wait_done("hold_first");
    chk("hold_first_r1", 64'(Result1), 64'(132));
    chk("hold_first_r2", 64'(Result2), 64'(0));
    chk("hold_done_busy", 64'(Busy), 64'(1));
    @(negedge CLK);
    Start = 1'b0;
    #3 chk("hold_done_width", 64'(Done), 64'(0));
    wait_done("hold_second");
    chk("hold_second_r1", 64'(Result1), 64'(1));
    chk("hold_second_r2", 64'(Result2), 64'(22));
    @(negedge CLK);
    #3 chk("hold_second_width", 64'(Done), 64'(0));
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
